// File: rtl/game_round_ctrl_if.sv
// Bundle of the game controller's player, counter and status signals.
// The slave side is the controller; the master side is whatever drives
// the players and watches the result (game logic, bench, etc.).
interface game_round_ctrl_if;
   logic       start;
   logic [3:0] seed;
   logic       p0_req;
   logic       p1_req;
   logic [1:0] p0_mode;
   logic [1:0] p1_mode;
   logic       winner;
   logic       loser;
   logic [1:0] up_down;
   logic       cnt_en;
   logic [3:0] initvalue;
   logic       init_load;
   logic       p0_gnt;
   logic       p1_gnt;
   logic       busy;
   logic [2:0] state;
   logic [3:0] p0_score;
   logic [3:0] p1_score;
   logic       game_done;
   logic [1:0] champ;

   modport master (
      output start, seed, p0_req, p1_req, p0_mode, p1_mode, winner, loser,
      input  up_down, cnt_en, initvalue, init_load, p0_gnt, p1_gnt, busy,
             state, p0_score, p1_score, game_done, champ
   );

   modport slave (
      input  start, seed, p0_req, p1_req, p0_mode, p1_mode, winner, loser,
      output up_down, cnt_en, initvalue, init_load, p0_gnt, p1_gnt, busy,
             state, p0_score, p1_score, game_done, champ
   );
endinterface

// File: rtl/game_round_ctrl.sv
// Two-player round controller for an up/down counter game.
// Each round the shared counter is loaded with the game seed; players take
// turns (round-robin on contention) stepping it. When the counter reports
// reaching 15 (winner) or 0 (loser) the round is scored; an idle PLAY phase
// of TIMEOUT cycles forfeits the round. After ROUNDS rounds the champion
// is published. Every output is a flop; the comb process computes next values.
module game_round_ctrl #(
   parameter int ROUNDS  = 4,
   parameter int TIMEOUT = 8,
   parameter int SETTLE  = 2
) (
   input  logic              clk,
   input  logic              reset,
   game_round_ctrl_if.slave  bus
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      PLAY  = 3'd2,
      WAIT  = 3'd3,
      SCORE = 3'd4,
      DONE  = 3'd5
   } state_t;

   // How the round in progress ended; resolved into points in SCORE.
   typedef enum logic [1:0] {
      OUT_WIN     = 2'd0,
      OUT_LOSE    = 2'd1,
      OUT_FORFEIT = 2'd2
   } outcome_t;

   state_t        state_reg,       state_next;
   outcome_t      outcome_reg,     outcome_next;
   logic [3:0]    seed_reg,        seed_next;
   logic [3:0]    round_reg,       round_next;
   logic          ptr_reg,         ptr_next;        // 0: p0 has priority
   logic          owner_reg,       owner_next;      // last granted player
   logic          owner_valid_reg, owner_valid_next;
   logic [TW-1:0] timer_reg,       timer_next;
   logic [SW-1:0] wait_reg,        wait_next;
   logic [3:0]    p0_score_reg,    p0_score_next;
   logic [3:0]    p1_score_reg,    p1_score_next;
   logic [1:0]    up_down_reg,     up_down_next;
   logic          cnt_en_reg,      cnt_en_next;
   logic [3:0]    initvalue_reg,   initvalue_next;
   logic          init_load_reg,   init_load_next;
   logic          p0_gnt_reg,      p0_gnt_next;
   logic          p1_gnt_reg,      p1_gnt_next;
   logic          busy_reg,        busy_next;
   logic          game_done_reg,   game_done_next;
   logic [1:0]    champ_reg,       champ_next;

   // Helpers for the comb process.
   logic [3:0]    seed_fix;
   logic          grant_p1;
   logic          p0_pt;
   logic          p1_pt;
   logic [3:0]    round_inc;

   function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic add);
      if (add && v != 4'd15)
         return v + 4'd1;
      return v;
   endfunction

   function automatic logic [1:0] pick_champ(input logic [3:0] s0, input logic [3:0] s1);
      if (s0 > s1)
         return 2'b01;
      if (s1 > s0)
         return 2'b10;
      return 2'b11;
   endfunction

   // State and output registers; reset wins over everything on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= IDLE;
         outcome_reg     <= OUT_WIN;
         seed_reg        <= 4'd1;
         round_reg       <= 4'd0;
         ptr_reg         <= 1'b0;
         owner_reg       <= 1'b0;
         owner_valid_reg <= 1'b0;
         timer_reg       <= '0;
         wait_reg        <= '0;
         p0_score_reg    <= 4'd0;
         p1_score_reg    <= 4'd0;
         up_down_reg     <= 2'b00;
         cnt_en_reg      <= 1'b0;
         initvalue_reg   <= 4'd1;
         init_load_reg   <= 1'b0;
         p0_gnt_reg      <= 1'b0;
         p1_gnt_reg      <= 1'b0;
         busy_reg        <= 1'b0;
         game_done_reg   <= 1'b0;
         champ_reg       <= 2'b00;
      end else begin
         state_reg       <= state_next;
         outcome_reg     <= outcome_next;
         seed_reg        <= seed_next;
         round_reg       <= round_next;
         ptr_reg         <= ptr_next;
         owner_reg       <= owner_next;
         owner_valid_reg <= owner_valid_next;
         timer_reg       <= timer_next;
         wait_reg        <= wait_next;
         p0_score_reg    <= p0_score_next;
         p1_score_reg    <= p1_score_next;
         up_down_reg     <= up_down_next;
         cnt_en_reg      <= cnt_en_next;
         initvalue_reg   <= initvalue_next;
         init_load_reg   <= init_load_next;
         p0_gnt_reg      <= p0_gnt_next;
         p1_gnt_reg      <= p1_gnt_next;
         busy_reg        <= busy_next;
         game_done_reg   <= game_done_next;
         champ_reg       <= champ_next;
      end
   end

   // Next-state and next-output logic; strobes default low each cycle.
   always_comb begin
      state_next       = state_reg;
      outcome_next     = outcome_reg;
      seed_next        = seed_reg;
      round_next       = round_reg;
      ptr_next         = ptr_reg;
      owner_next       = owner_reg;
      owner_valid_next = owner_valid_reg;
      timer_next       = timer_reg;
      wait_next        = wait_reg;
      p0_score_next    = p0_score_reg;
      p1_score_next    = p1_score_reg;
      up_down_next     = 2'b00;
      cnt_en_next      = 1'b0;
      initvalue_next   = initvalue_reg;
      init_load_next   = 1'b0;
      p0_gnt_next      = 1'b0;
      p1_gnt_next      = 1'b0;
      game_done_next   = game_done_reg;
      champ_next       = champ_reg;

      // A seed of 0 or 15 would end the round before anyone moves.
      seed_fix  = (bus.seed == 4'd0 || bus.seed == 4'd15) ? 4'd1 : bus.seed;
      grant_p1  = (bus.p0_req && bus.p1_req) ? ptr_reg : bus.p1_req;
      p0_pt     = 1'b0;
      p1_pt     = 1'b0;
      round_inc = round_reg + 4'd1;

      case (state_reg)
         IDLE, DONE: begin
            if (bus.start) begin
               seed_next      = seed_fix;
               round_next     = 4'd0;
               ptr_next       = 1'b0;
               p0_score_next  = 4'd0;
               p1_score_next  = 4'd0;
               game_done_next = 1'b0;
               champ_next     = 2'b00;
               init_load_next = 1'b1;
               initvalue_next = seed_fix;
               state_next     = LOAD;
            end
         end
         LOAD: begin
            owner_valid_next = 1'b0;
            timer_next       = '0;
            state_next       = PLAY;
         end
         PLAY: begin
            if (bus.winner || bus.loser) begin
               outcome_next = bus.winner ? OUT_WIN : OUT_LOSE;
               state_next   = SCORE;
            end else if (bus.p0_req || bus.p1_req) begin
               p0_gnt_next      = ~grant_p1;
               p1_gnt_next      = grant_p1;
               cnt_en_next      = 1'b1;
               up_down_next     = grant_p1 ? bus.p1_mode : bus.p0_mode;
               owner_next       = grant_p1;
               owner_valid_next = 1'b1;
               ptr_next         = ~grant_p1;
               timer_next       = '0;
               wait_next        = '0;
               state_next       = WAIT;
            end else begin
               timer_next = timer_reg + TW'(1);
               if (timer_reg == TW'(TIMEOUT - 1)) begin
                  outcome_next = OUT_FORFEIT;
                  state_next   = SCORE;
               end
            end
         end
         WAIT: begin
            if (wait_reg == SW'(SETTLE - 1))
               state_next = PLAY;
            else
               wait_next = wait_reg + SW'(1);
         end
         SCORE: begin
            case (outcome_reg)
               OUT_WIN: begin
                  p0_pt = owner_valid_reg & ~owner_reg;
                  p1_pt = owner_valid_reg &  owner_reg;
               end
               OUT_LOSE: begin
                  p0_pt = owner_valid_reg &  owner_reg;
                  p1_pt = owner_valid_reg & ~owner_reg;
               end
               default: begin
                  p0_pt =  ptr_reg;
                  p1_pt = ~ptr_reg;
               end
            endcase
            p0_score_next = sat_inc(p0_score_reg, p0_pt);
            p1_score_next = sat_inc(p1_score_reg, p1_pt);
            round_next    = round_inc;
            if (round_inc == 4'(ROUNDS)) begin
               game_done_next = 1'b1;
               champ_next     = pick_champ(p0_score_next, p1_score_next);
               state_next     = DONE;
            end else begin
               init_load_next = 1'b1;
               initvalue_next = seed_reg;
               state_next     = LOAD;
            end
         end
         default: state_next = IDLE;
      endcase

      busy_next = !(state_next == IDLE || state_next == DONE);
   end

   assign bus.state     = state_reg;
   assign bus.up_down   = up_down_reg;
   assign bus.cnt_en    = cnt_en_reg;
   assign bus.initvalue = initvalue_reg;
   assign bus.init_load = init_load_reg;
   assign bus.p0_gnt    = p0_gnt_reg;
   assign bus.p1_gnt    = p1_gnt_reg;
   assign bus.busy      = busy_reg;
   assign bus.p0_score  = p0_score_reg;
   assign bus.p1_score  = p1_score_reg;
   assign bus.game_done = game_done_reg;
   assign bus.champ     = champ_reg;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: directed rounds plus biased random play,
// every cycle compared against a round-level reference model.
module tb_game_round_ctrl;
   localparam int ROUNDS  = 4;
   localparam int TIMEOUT = 8;
   localparam int SETTLE  = 2;

   logic clk = 1'b0;
   logic reset;
   game_round_ctrl_if bus();

   game_round_ctrl #(.ROUNDS(ROUNDS), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: phase of the game (using the published state codes),
   // scores, and who gets the point once the round is decided.
   int m_phase, m_seed, m_s0, m_s1, m_round, m_ptr, m_idle, m_wait_left;
   int m_owner, m_owner_ok, m_point_to, m_gnt, m_ud, m_load, m_initv;

   task automatic model_step();
      m_gnt  = -1;
      m_load = 0;
      if (reset) begin
         m_phase = 0; m_s0 = 0; m_s1 = 0; m_round = 0; m_ptr = 0;
         m_idle = 0; m_initv = 1; m_owner_ok = 0;
         return;
      end
      case (m_phase)
         0, 5: if (bus.start) begin
            m_seed = (bus.seed == 0 || bus.seed == 15) ? 1 : int'(bus.seed);
            m_s0 = 0; m_s1 = 0; m_round = 0; m_ptr = 0;
            m_load = 1; m_initv = m_seed; m_phase = 1;
         end
         1: begin m_owner_ok = 0; m_idle = 0; m_phase = 2; end
         2: begin
            if (bus.winner || bus.loser) begin
               if (!m_owner_ok) m_point_to = -1;
               else if (bus.winner) m_point_to = m_owner;
               else m_point_to = 1 - m_owner;
               m_phase = 4;
            end else if (bus.p0_req || bus.p1_req) begin
               if (bus.p0_req && bus.p1_req) m_gnt = m_ptr;
               else m_gnt = bus.p1_req ? 1 : 0;
               m_ud = (m_gnt == 1) ? int'(bus.p1_mode) : int'(bus.p0_mode);
               m_owner = m_gnt; m_owner_ok = 1; m_ptr = 1 - m_gnt;
               m_idle = 0; m_wait_left = SETTLE; m_phase = 3;
            end else begin
               m_idle++;
               if (m_idle >= TIMEOUT) begin
                  m_point_to = 1 - m_ptr;
                  m_phase = 4;
               end
            end
         end
         3: begin m_wait_left--; if (m_wait_left == 0) m_phase = 2; end
         4: begin
            if (m_point_to == 0 && m_s0 < 15) m_s0++;
            if (m_point_to == 1 && m_s1 < 15) m_s1++;
            m_round++;
            if (m_round == ROUNDS) m_phase = 5;
            else begin m_phase = 1; m_load = 1; m_initv = m_seed; end
         end
         default: m_phase = 0;
      endcase
   endtask

   task automatic compare_all();
      int champ_exp;
      champ_exp = 0;
      if (m_phase == 5) champ_exp = (m_s0 > m_s1) ? 1 : (m_s1 > m_s0) ? 2 : 3;
      check("state",     bus.state,     m_phase);
      check("p0_gnt",    bus.p0_gnt,    int'(m_gnt == 0));
      check("p1_gnt",    bus.p1_gnt,    int'(m_gnt == 1));
      check("cnt_en",    bus.cnt_en,    int'(m_gnt >= 0));
      check("up_down",   bus.up_down,   (m_gnt >= 0) ? m_ud : 0);
      check("init_load", bus.init_load, m_load);
      check("initvalue", bus.initvalue, m_initv);
      check("p0_score",  bus.p0_score,  m_s0);
      check("p1_score",  bus.p1_score,  m_s1);
      check("busy",      bus.busy,      int'(!(m_phase == 0 || m_phase == 5)));
      check("game_done", bus.game_done, int'(m_phase == 5));
      check("champ",     bus.champ,     champ_exp);
   endtask

   // One clock: DUT and model consume the same inputs, outputs are checked
   // 1 ns after the edge, and new inputs are applied on the falling edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      @(negedge clk);
   endtask

   task automatic quiet_inputs();
      reset = 0; bus.start = 0; bus.seed = 4'd0;
      bus.p0_req = 0; bus.p1_req = 0; bus.p0_mode = 2'd0; bus.p1_mode = 2'd0;
      bus.winner = 0; bus.loser = 0;
   endtask

   int p_req0[6] = '{50, 100,  0, 10, 60, 30};
   int p_req1[6] = '{50, 100,  0, 10, 20, 70};
   int p_wl[6]   = '{30,  20,  0, 10, 40, 40};  // per mille, each of winner/loser
   int p_start[6]= '{20,  20, 30, 20, 50, 10};
   int p_rst[6]  = '{ 3,   0,  0,  2,  5,  8};  // per mille

   initial begin
      int grants;
      bit hit;
      quiet_inputs();
      reset = 1;
      tick();
      tick();
      reset = 0;

      // Basic round: seed 5, only p0 stepping with +2, winner after 3 steps.
      bus.seed = 4'd5; bus.start = 1;
      tick();
      bus.start = 0; bus.p0_req = 1; bus.p0_mode = 2'b01;
      grants = 0; hit = 0;
      for (int i = 0; i < 80 && !hit; i++) begin
         bus.winner = (grants >= 3 && m_phase == 2);
         tick();
         if (m_gnt == 0) grants++;
         if (m_phase == 4) hit = 1;
      end
      bus.winner = 0;
      check("basic_reached_score", int'(hit), 1);
      tick();
      check("basic_p0_score", bus.p0_score, 1);
      check("basic_grants", grants, 3);

      // Reset while waiting after a grant must drop the round silently.
      hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
         tick();
         if (m_phase == 3) hit = 1;
      end
      check("wait_reached", int'(hit), 1);
      reset = 1;
      tick();
      reset = 0;
      check("rst_wait_state", bus.state, 0);
      check("rst_wait_score", bus.p0_score, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rst_no_cnt_en", bus.cnt_en, 0);
      end
      bus.p0_req = 0;

      // Biased random play, one probability profile per scenario.
      for (int s = 0; s < 6; s++) begin
         for (int c = 0; c < 700; c++) begin
            reset       = ($urandom_range(999) < p_rst[s]);
            bus.start   = ($urandom_range(99) < p_start[s]);
            bus.seed    = 4'($urandom_range(15));
            bus.p0_req  = ($urandom_range(99) < p_req0[s]);
            bus.p1_req  = ($urandom_range(99) < p_req1[s]);
            bus.p0_mode = 2'($urandom_range(3));
            bus.p1_mode = 2'($urandom_range(3));
            bus.winner  = ($urandom_range(999) < p_wl[s]);
            bus.loser   = ($urandom_range(999) < p_wl[s]);
            tick();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 Parameters SHALL be: ROUNDS, 4, rounds per game (1..15); TIMEOUT, 8, idle PLAY cycles before forfeit (>=2); SETTLE, 2, wait cycles after each step (>=1).
REQ-002 Ports SHALL be (name  dir  width  meaning):
  clk  in  1  sole clock, rising edge;
  reset  in  1  synchronous, active-high;
  start  in  1  begin game (sampled in IDLE/DONE);
  seed  in  4  round start value, captured on start;
  p0_req / p1_req  in  1  player step request;
  p0_mode / p1_mode  in  2  step code (00 +1, 01 +2, 10 -1, 11 -2);
  winner / loser  in  1  counter reached 15 / 0;
  up_down  out  2  step code to counter;
  cnt_en  out  1  step-valid strobe;
  initvalue  out  4  load value to counter;
  init_load  out  1  load strobe;
  p0_gnt / p1_gnt  out  1  grant strobe;
  busy  out  1  high in any state except IDLE and DONE;
  state  out  3  FSM state code;
  p0_score / p1_score  out  4  round wins;
  game_done  out  1  high in DONE;
  champ  out  2  01 p0, 10 p1, 11 tie, 00 none.

Function
REQ-003 All outputs SHALL be registered; FSM codes SHALL be IDLE=0, LOAD=1, PLAY=2, WAIT=3, SCORE=4, DONE=5.
REQ-004 IDLE: start=1 -> capture seed (0 or 15 replaced by 1), clear scores and round count, go LOAD.
REQ-005 LOAD: init_load=1 and initvalue=captured seed for exactly one cycle; clear owner_valid and idle timer; go PLAY.
REQ-006 PLAY, priority order each cycle: winner|loser=1 -> SCORE; else a request -> grant; else idle timer +1, timer reaching TIMEOUT -> forfeit -> SCORE.
REQ-007 Grant: round-robin pointer, p0 after reset/start; one requester -> that player; both -> pointer's player; pointer then moves to the other player.
REQ-008 Grant cycle: req sampled at edge N; gntX=1, cnt_en=1, up_down=granted mode during cycle N+1 only; owner=granted player, owner_valid=1, idle timer cleared; go WAIT.
REQ-009 When cnt_en=0, up_down SHALL be 00; at most one gnt and one cnt_en pulse per grant; no grants outside PLAY.
REQ-010 WAIT: hold SETTLE cycles, then return to PLAY; winner/loser evaluated only in PLAY.
REQ-011 SCORE (one cycle): winner -> owner +1; loser -> non-owner +1; both high -> treat as winner; owner_valid=0 -> no point; forfeit -> non-pointer player +1; scores saturate at 15.
REQ-012 SCORE: round count +1; count=ROUNDS -> DONE, else LOAD (same seed).
REQ-013 DONE: game_done=1; champ by score compare (equal -> 11); start=1 -> behaves as IDLE start (scores cleared, champ=00).
REQ-014 start outside IDLE/DONE SHALL be ignored.

Reset
REQ-015 reset=1 at an edge SHALL force, same edge, from any state: state=IDLE, all strobes/grants 0, up_down=00, initvalue=0001, scores 0, champ 00, game_done 0, busy 0, pointer p0, timer/round count 0.
REQ-016 Reset mid-PLAY/WAIT SHALL discard the round in progress with no score update.

Verification
REQ-017 Basic round: seed=5, start, p0_req only mode 01, winner at 3rd step -> init_load pulse with initvalue=5, three p0_gnt pulses each SETTLE+1 apart, p0_score=1.
REQ-018 Arbitration: p0_req and p1_req held high -> gnt order p0,p1,p0,p1, one cycle each, never both high.
REQ-019 Loser credit: p1 last mover, loser=1 -> p0_score +1; winner and loser together -> mover credited.
REQ-020 Timeout: no requests for 8 PLAY cycles, pointer=p0 -> p1_score +1, next round starts via LOAD.
REQ-021 Full game: ROUNDS=4, p0 wins 3 and p1 wins 1 -> DONE, game_done=1, champ=01; 2-2 -> champ=11; seed=0 -> initvalue=1.
REQ-022 Reset in WAIT after a grant -> next cycle state=IDLE, scores 0, no further cnt_en.
